// File: rtl/note_gen.sv
// note_gen: square-wave note generator feeding the stereo DAC serializer.
// Accepts one note (half-period, volume, duration) over a valid/ready
// handshake, plays it as a signed 16-bit square wave on both channels for
// dur ms ticks, then holds a silent gap of GAP_MS ticks before returning idle.
//
// Ports:
//   clk, rst          - clock, synchronous active-high reset
//   note_valid/ready  - note handshake (ready only while idle)
//   note_div [19:0]   - half-period in clk cycles, 0 = rest
//   note_vol [3:0]    - volume 0..15, amplitude = vol * 2048
//   note_dur [11:0]   - note length in ms ticks, 0 = ignored
//   audio_left/right  - signed samples, both channels identical
//   busy              - high while playing or in the gap
//
// Optional feature: define NOTE_GEN_FADE_EN to decrement the working volume
// every FADE_MS ticks during a note (saturating at 0).
module note_gen #(
  parameter int TICK_DIV = 40000,
  parameter int GAP_MS   = 10,
  parameter int FADE_MS  = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        note_valid,
  output logic        note_ready,
  input  logic [19:0] note_div,
  input  logic [3:0]  note_vol,
  input  logic [11:0] note_dur,
  output logic [15:0] audio_left,
  output logic [15:0] audio_right,
  output logic        busy
);

  localparam int PRE_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int MS_W  = (GAP_MS > 4096) ? $clog2(GAP_MS) : 12;

  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(TICK_DIV - 1);
  localparam logic [MS_W-1:0]  GAP_LAST = MS_W'(GAP_MS - 1);

  if (TICK_DIV < 1 || GAP_MS < 1 || FADE_MS < 1) begin : g_param_check
    $error("note_gen: TICK_DIV, GAP_MS and FADE_MS must all be >= 1");
  end

  typedef enum logic [1:0] {
    S_IDLE,
    S_PLAY,
    S_GAP
  } state_t;

  state_t           state, state_n;
  logic [19:0]      div_r, div_n;
  logic [19:0]      hc, hc_n;
  logic [3:0]       vol_r, vol_n;
  logic [11:0]      dur_r, dur_n;
  logic [PRE_W-1:0] pre, pre_n;
  logic [MS_W-1:0]  ms, ms_n;
  logic             phase, phase_n;
  logic [15:0]      audio_r, audio_n;
  logic             ready_n;
  logic             tick;

`ifdef NOTE_GEN_FADE_EN
  localparam int FADE_W = (FADE_MS > 1) ? $clog2(FADE_MS) : 1;
  localparam logic [FADE_W-1:0] FADE_LAST = FADE_W'(FADE_MS - 1);
  logic [FADE_W-1:0] fcnt, fcnt_n;
`endif

  function automatic logic [15:0] sample(input logic [19:0] d,
                                         input logic [3:0]  v,
                                         input logic        ph);
    logic [15:0] amp;
    amp = {1'b0, v, 11'b0};
    if (d == '0 || v == '0) begin
      return '0;
    end
    return ph ? amp : (~amp + 16'd1);
  endfunction

  assign tick = (pre == PRE_LAST);

  // The output sample is computed from the next-cycle phase/volume so the
  // registered audio lines up with the state it belongs to.
  always_comb begin
    state_n = state;
    div_n   = div_r;
    hc_n    = hc;
    vol_n   = vol_r;
    dur_n   = dur_r;
    pre_n   = pre;
    ms_n    = ms;
    phase_n = phase;
    audio_n = '0;
`ifdef NOTE_GEN_FADE_EN
    fcnt_n  = fcnt;
`endif

    case (state)
      S_IDLE: begin
        if (note_valid && note_ready && note_dur != '0) begin
          state_n = S_PLAY;
          div_n   = note_div;
          vol_n   = note_vol;
          dur_n   = note_dur;
          hc_n    = '0;
          pre_n   = '0;
          ms_n    = '0;
          phase_n = 1'b1;
`ifdef NOTE_GEN_FADE_EN
          fcnt_n  = '0;
`endif
          audio_n = sample(note_div, note_vol, 1'b1);
        end
      end

      S_PLAY: begin
        if (tick) begin
          pre_n = '0;
          ms_n  = ms + 1'b1;
        end else begin
          pre_n = pre + 1'b1;
        end

        if (div_r != '0) begin
          if (hc == div_r - 20'd1) begin
            hc_n    = '0;
            phase_n = ~phase;
          end else begin
            hc_n = hc + 20'd1;
          end
        end

`ifdef NOTE_GEN_FADE_EN
        if (tick) begin
          if (fcnt == FADE_LAST) begin
            fcnt_n = '0;
            if (vol_r != '0) begin
              vol_n = vol_r - 4'd1;
            end
          end else begin
            fcnt_n = fcnt + 1'b1;
          end
        end
`endif

        if (tick && ms == MS_W'(dur_r - 12'd1)) begin
          state_n = S_GAP;
          pre_n   = '0;
          ms_n    = '0;
        end else begin
          audio_n = sample(div_r, vol_n, phase_n);
        end
      end

      S_GAP: begin
        if (tick) begin
          pre_n = '0;
          ms_n  = ms + 1'b1;
          if (ms == GAP_LAST) begin
            state_n = S_IDLE;
            ms_n    = '0;
          end
        end else begin
          pre_n = pre + 1'b1;
        end
      end

      default: begin
        state_n = S_IDLE;
      end
    endcase

    ready_n = (state_n == S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      div_r      <= '0;
      hc         <= '0;
      vol_r      <= '0;
      dur_r      <= '0;
      pre        <= '0;
      ms         <= '0;
      phase      <= 1'b0;
      audio_r    <= '0;
      note_ready <= 1'b1;
      busy       <= 1'b0;
`ifdef NOTE_GEN_FADE_EN
      fcnt       <= '0;
`endif
    end else begin
      state      <= state_n;
      div_r      <= div_n;
      hc         <= hc_n;
      vol_r      <= vol_n;
      dur_r      <= dur_n;
      pre        <= pre_n;
      ms         <= ms_n;
      phase      <= phase_n;
      audio_r    <= audio_n;
      note_ready <= ready_n;
      busy       <= ~ready_n;
`ifdef NOTE_GEN_FADE_EN
      fcnt       <= fcnt_n;
`endif
    end
  end

  assign audio_left  = audio_r;
  assign audio_right = audio_r;

endmodule
